alu_op_sequencer: RTL and testbench

Push-button-driven controller that sequences one ALU operation from board switches. It sits between the debounced push-button outputs and the ALU, and presents a frozen result to the display logic. Successive presses of one "next" button capture operand A, then operand B, then the opcode, then launch the ALU and wait for completion under a timeout. A second button aborts and clears the sequence at any point.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_op_sequencer_btn_edge.sv | 30 +++
 rtl/alu_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU operation sequencer and the ALU.
//   state_t : 3-bit sequencer state. The encodings are shown on the
//             state LEDs, so each one is fixed explicitly.
//   OP_W    : opcode width shared with the ALU.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GOT_A  = 3'd1,
    ST_GOT_B  = 3'd2,
    ST_GOT_OP = 3'd3,
    ST_EXEC   = 3'd4,
    ST_SHOW   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_btn_edge.sv
// btn_edge: turns a debounced button level into a one-cycle press pulse.
// Ports:
//   Clk   : system clock, rising edge
//   Rst_n : asynchronous active-low reset
//   level : debounced button level
//   press : high for one cycle after the button goes from released to pressed
module btn_edge (
  input  logic Clk,
  input  logic Rst_n,
  input  logic level,
  output logic press
);

  // This register records that the button was seen released in the previous
  // cycle. It resets to 0 ("not seen released"). As a result, a button that
  // is still held when reset is released does not produce a press until the
  // button has first been let go.
  logic released;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      released <= 1'b0;
    end else begin
      released <= ~level;
    end
  end

  assign press = level & released;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one ALU operation from board switches.
// Presses of the "next" button do the following, in order:
//   1. capture operand A
//   2. capture operand B
//   3. capture the opcode
//   4. launch the ALU
// The sequencer then waits for alu_done under a timeout. After that it shows
// the frozen result. The "clear" button aborts the sequence from any state.
// Ports:
//   Clk, Rst_n         : clock, asynchronous active-low reset
//   sw_in [WIDTH]      : switch value, sampled on a next press
//   btn_next, btn_clr  : debounced button levels
//   alu_a, alu_b       : registered operands
//   alu_op [OP_W]      : registered opcode
//   alu_go             : one-cycle launch pulse
//   alu_done           : ALU completion strobe (used only in EXEC)
//   alu_result [WIDTH] : ALU result, valid while alu_done is high
//   result_out [WIDTH] : latched result for the display
//   state_led [3]      : current state encoding
//   error              : sticky timeout flag
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int OP_W    = alu_pkg::OP_W,
  parameter int TIMEOUT = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             btn_next,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_go,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result_out,
  output logic [2:0]       state_led,
  output logic             error
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic press_next;
  logic press_clr;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] a_n, b_n, res_n;
  logic [OP_W-1:0]  op_n;
  logic             go_n, err_n;

  btn_edge u_next_edge (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .level (btn_next),
    .press (press_next)
  );

  btn_edge u_clr_edge (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .level (btn_clr),
    .press (press_clr)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_go     <= 1'b0;
      result_out <= '0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      alu_a      <= a_n;
      alu_b      <= b_n;
      alu_op     <= op_n;
      alu_go     <= go_n;
      result_out <= res_n;
      error      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = alu_a;
    b_n     = alu_b;
    op_n    = alu_op;
    go_n    = 1'b0;
    res_n   = result_out;
    err_n   = error;

    // Clear takes priority over a next press or alu_done arriving in the
    // same cycle.
    if (press_clr) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      a_n     = '0;
      b_n     = '0;
      op_n    = '0;
      res_n   = '0;
      err_n   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (press_next) begin
            a_n     = sw_in;
            state_n = ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (press_next) begin
            b_n     = sw_in;
            state_n = ST_GOT_B;
          end
        end
        ST_GOT_B: begin
          if (press_next) begin
            op_n    = sw_in[OP_W-1:0];
            state_n = ST_GOT_OP;
          end
        end
        ST_GOT_OP: begin
          if (press_next) begin
            go_n    = 1'b1;
            cnt_n   = '0;
            state_n = ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The counter is 0 in the alu_go cycle. When it reaches
          // TIMEOUT-1, error is set on the edge TIMEOUT cycles after
          // alu_go. An ALU that answers in the same cycle as alu_go is
          // therefore accepted.
          if (alu_done) begin
            res_n   = alu_result;
            state_n = ST_SHOW;
          end else if (cnt == CNT_LAST) begin
            err_n   = 1'b1;
            res_n   = '0;
            state_n = ST_SHOW;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          // A press here starts a new operation directly with operand A.
          if (press_next) begin
            a_n     = sw_in;
            err_n   = 1'b0;
            state_n = ST_GOT_A;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] sw_in;
  logic       btn_next;
  logic       btn_clr;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_go;
  logic       alu_done;
  logic [7:0] alu_result;
  logic [7:0] result_out;
  logic [2:0] state_led;
  logic       error;

  int vectors    = 0;
  int miscompares = 0;

  alu_op_sequencer #(.WIDTH(8), .OP_W(4), .TIMEOUT(16)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .sw_in      (sw_in),
    .btn_next   (btn_next),
    .btn_clr    (btn_clr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_go     (alu_go),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .result_out (result_out),
    .state_led  (state_led),
    .error      (error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press and release next. Returns on the falling edge that follows the
  // clock edge on which the press took effect.
  task automatic pulse_next(input logic [7:0] v);
    @(negedge Clk);
    sw_in    = v;
    btn_next = 1'b1;
    @(negedge Clk);
    btn_next = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge Clk);
    btn_clr = 1'b1;
    @(negedge Clk);
    btn_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},     32'(alu_a), 32'h0);
    check({tag, "_b"},     32'(alu_b), 32'h0);
    check({tag, "_op"},    32'(alu_op), 32'h0);
    check({tag, "_go"},    32'(alu_go), 32'h0);
    check({tag, "_res"},   32'(result_out), 32'h0);
    check({tag, "_state"}, 32'(state_led), 32'h0);
    check({tag, "_err"},   32'(error), 32'h0);
  endtask

  initial begin
    Rst_n      = 1'b0;
    sw_in      = 8'h00;
    btn_next   = 1'b0;
    btn_clr    = 1'b0;
    alu_done   = 1'b0;
    alu_result = 8'h00;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst_n = 1'b1;
    @(negedge Clk);

    // Basic operation: 5, 3, opcode 2, go; the ALU answers 8 two cycles later.
    pulse_next(8'h05);
    check("t1_state_a", 32'(state_led), 32'd1);
    check("t1_a", 32'(alu_a), 32'h05);
    pulse_next(8'h03);
    check("t1_state_b", 32'(state_led), 32'd2);
    check("t1_b", 32'(alu_b), 32'h03);
    pulse_next(8'h02);
    check("t1_state_op", 32'(state_led), 32'd3);
    check("t1_op", 32'(alu_op), 32'h2);
    check("t1_go_before", 32'(alu_go), 32'h0);
    pulse_next(8'hFF);
    check("t1_go", 32'(alu_go), 32'h1);
    check("t1_state_exec", 32'(state_led), 32'd4);
    @(negedge Clk);
    check("t1_go_single", 32'(alu_go), 32'h0);
    alu_done   = 1'b1;
    alu_result = 8'h08;
    @(negedge Clk);
    alu_done   = 1'b0;
    alu_result = 8'h00;
    check("t1_res", 32'(result_out), 32'h08);
    check("t1_state_show", 32'(state_led), 32'd5);
    check("t1_err", 32'(error), 32'h0);
    check("t1_a_hold", 32'(alu_a), 32'h05);

    // Timeout: SHOW -> new operation, with no alu_done.
    pulse_next(8'h01);
    check("t3_state_a", 32'(state_led), 32'd1);
    pulse_next(8'h02);
    pulse_next(8'h03);
    pulse_next(8'h00);
    check("t3_go", 32'(alu_go), 32'h1);
    repeat (15) @(negedge Clk);
    check("t3_err_early", 32'(error), 32'h0);
    check("t3_state_exec", 32'(state_led), 32'd4);
    check("t3_res_held", 32'(result_out), 32'h08);
    @(negedge Clk);
    check("t3_err", 32'(error), 32'h1);
    check("t3_res_zero", 32'(result_out), 32'h0);
    check("t3_state_show", 32'(state_led), 32'd5);
    pulse_next(8'h0A);
    check("t3_err_clr", 32'(error), 32'h0);
    check("t3_a", 32'(alu_a), 32'h0A);
    check("t3_state_a2", 32'(state_led), 32'd1);

    // Clear from GOT_A.
    pulse_clr();
    check("clr_state", 32'(state_led), 32'd0);
    check("clr_a", 32'(alu_a), 32'h0);
    check("clr_b", 32'(alu_b), 32'h0);

    // Holding next for 100 cycles advances the state once.
    @(negedge Clk);
    sw_in    = 8'h11;
    btn_next = 1'b1;
    repeat (100) @(negedge Clk);
    check("hold_state", 32'(state_led), 32'd1);
    check("hold_a", 32'(alu_a), 32'h11);
    check("hold_b", 32'(alu_b), 32'h0);
    btn_next = 1'b0;

    // alu_done in GOT_A is ignored.
    @(negedge Clk);
    alu_done   = 1'b1;
    alu_result = 8'hEE;
    @(negedge Clk);
    alu_done   = 1'b0;
    alu_result = 8'h00;
    check("done_ign_state", 32'(state_led), 32'd1);
    check("done_ign_res", 32'(result_out), 32'h0);

    // Simultaneous next and clear in GOT_B: clear wins.
    pulse_next(8'h22);
    check("sim_state_b", 32'(state_led), 32'd2);
    check("sim_b", 32'(alu_b), 32'h22);
    @(negedge Clk);
    sw_in    = 8'h07;
    btn_next = 1'b1;
    btn_clr  = 1'b1;
    @(negedge Clk);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    check_all_zero("sim");

    // Asynchronous reset mid-EXEC; next is held through the release.
    pulse_next(8'h31);
    pulse_next(8'h32);
    pulse_next(8'h03);
    pulse_next(8'h00);
    check("ar_state_exec", 32'(state_led), 32'd4);
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    btn_next = 1'b1;
    sw_in    = 8'h44;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("ar_held_state", 32'(state_led), 32'd0);
    check("ar_held_a", 32'(alu_a), 32'h0);
    btn_next = 1'b0;
    pulse_next(8'h33);
    check("ar_after_state", 32'(state_led), 32'd1);
    check("ar_after_a", 32'(alu_a), 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
